// File: rtl/mem_pkg.sv
// mem_pkg: bus command codes, responder FSM states and default MMIO addresses
package mem_pkg;
  localparam logic [1:0] MNONE = 2'b00;
  localparam logic [1:0] MREAD = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam logic [1:0] MILLEGAL = 2'b11;
  localparam logic [8:0] DEF_LED_ADDR = 9'h100;
  localparam logic [8:0] DEF_SW_ADDR = 9'h140;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs, cleared by rst
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s1_d, s2_q, s2_d;
  // shift the raw input through two stages
  always_comb begin
    s1_d = rst ? '0 : d;
    s2_d = rst ? '0 : s1_q;
  end
  // stage registers
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end
  assign q = s2_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: RAM + MMIO (LED/switch) bus responder with wait states; MMIO decode enabled by MEM_MMIO_EN
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RAM_DEPTH = 256,
  parameter int WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(DEF_LED_ADDR),
  parameter logic [ADDR_W-1:0] SW_ADDR = ADDR_W'(DEF_SW_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              err
);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W+1)'(RAM_DEPTH);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic ready_q, ready_d, err_q, err_d;
  logic [7:0] led_q, led_d, sw_sync;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic in_ram, is_led, is_sw, start, ram_we;
`ifdef MEM_MMIO_EN
  sync_2ff #(.W(8)) u_sw_sync (.clk(clk), .rst(rst), .d(sw), .q(sw_sync));
  assign is_led = addr_q == LED_ADDR;
  assign is_sw = addr_q == SW_ADDR;
`else
  logic [7:0] unused_sw;
  assign unused_sw = sw;
  assign sw_sync = '0;
  assign is_led = 1'b0;
  assign is_sw = 1'b0;
`endif
  assign in_ram = {1'b0, addr_q} < RAM_LIM;
  assign start = state_q == IDLE && (mem_cmd == MREAD || mem_cmd == MWRITE);
  assign ram_we = !rst && state_q == DONE && cmd_q == MWRITE && in_ram;
  // next-state: latch in IDLE, count down in BUSY, complete the access in DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d = err_q;
    led_d = led_q;
    if (start) begin
      state_d = WAIT_STATES == 0 ? DONE : BUSY;
      cnt_d = 4'(WAIT_STATES);
      cmd_d = mem_cmd;
      addr_d = mem_addr;
      wdata_d = write_data;
    end else if (state_q == IDLE) begin
      err_d = err_q | (mem_cmd == MILLEGAL);
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? DONE : BUSY;
    end else begin
      state_d = IDLE;
      ready_d = 1'b1;
      rdata_d = cmd_q != MREAD ? rdata_q :
                in_ram ? ram_q[addr_q[RAM_AW-1:0]] :
                is_led ? DATA_W'(led_q) :
                is_sw ? DATA_W'(sw_sync) : '0;
      led_d = (cmd_q == MWRITE && !in_ram && is_led) ? wdata_q[7:0] : led_q;
      err_d = err_q | !(in_ram || is_led || is_sw);
    end
    if (rst) begin
      state_d = IDLE;
      cnt_d = '0;
      rdata_d = '0;
      ready_d = 1'b0;
      err_d = 1'b0;
      led_d = '0;
    end
  end
  // control and output registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    cmd_q <= cmd_d;
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    ready_q <= ready_d;
    err_q <= err_d;
    led_q <= led_d;
  end
  // RAM write port, committed only in DONE
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[addr_q[RAM_AW-1:0]] <= wdata_q;
  end
  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign led = led_q;
  assign err = err_q;
endmodule
